// File: rtl/tick_sched_pkg.sv
// Shared types, defaults and the divide-ratio clamp for the tick scheduler.
package tick_sched_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int DEF_DIV_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    // A requested ratio of 0 means "divide by 1".
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Modulo counter with synchronous clear, modulus load and terminal-count flag.
module tick_counter #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] DEF_MOD = 10
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] mod_i,
    output logic             tc_o,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic [CNT_W-1:0] mod_nxt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] mod_q, mod_d;

    assign tc_o = (cnt_q == mod_q - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        mod_d = load_i ? mod_i : mod_q;
    end

    // Next-state values let the owner register outputs that line up with the count.
    assign cnt_nxt_o = cnt_d;
    assign mod_nxt_o = mod_d;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            cnt_q <= '0;
            mod_q <= DEF_MOD;
        end else begin
            cnt_q <= cnt_d;
            mod_q <= mod_d;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Start/stop sequencer for a modulo-N divider with boundary-aligned ratio changes.
// Optional tick budget (iBurst) is built when TICK_SCHED_BURST_EN is defined.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iStart,
    input  logic             iStop,
    input  logic [CNT_W-1:0] iDiv,
    input  logic             iDiv_valid,
    output logic             oDiv_ready,
    output logic             oTick,
    output logic             oClock_out,
    output logic             oBusy,
    output logic [CNT_W-1:0] oTick_count
`ifdef TICK_SCHED_BURST_EN
    ,
    input  logic [CNT_W-1:0] iBurst
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] tick_count_q, tick_count_d, tcnt_base;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic             clr, en, load, tc, xfer, run_d, burst_done;
    logic [CNT_W-1:0] load_val, div_in, cnt_nxt, mod_nxt;

`ifdef TICK_SCHED_BURST_EN
    logic [CNT_W-1:0] burst_q, burst_d;
`endif

    assign div_in = CNT_W'(clamp_div(32'(iDiv)));
    assign xfer   = iDiv_valid & ready_q;

    tick_counter #(
        .CNT_W   (CNT_W),
        .DEF_MOD (CNT_W'(DEF_DIV))
    ) u_cnt (
        .iClock    (iClock),
        .iReset    (iReset),
        .clr_i     (clr),
        .en_i      (en),
        .load_i    (load),
        .mod_i     (load_val),
        .tc_o      (tc),
        .cnt_nxt_o (cnt_nxt),
        .mod_nxt_o (mod_nxt)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        clr       = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        load_val  = div_in;
        tcnt_base = tick_count_q;
`ifdef TICK_SCHED_BURST_EN
        burst_d    = burst_q;
        burst_done = (burst_q != '0) && tick_q && (tick_count_q == burst_q);
`else
        burst_done = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                load = xfer;
                if (iStart && !iStop) begin
                    state_d   = RUN;
                    clr       = 1'b1;
                    tcnt_base = '0;
`ifdef TICK_SCHED_BURST_EN
                    burst_d   = iBurst;
`endif
                end
            end
            RUN, PEND: begin
                if (iStop || burst_done) begin
                    // Stopping commits any waiting ratio so it is not lost.
                    state_d = IDLE;
                    clr     = 1'b1;
                    if (state_q == PEND) begin
                        load     = 1'b1;
                        load_val = pend_q;
                    end
                end else begin
                    en = 1'b1;
                    if (state_q == RUN) begin
                        if (xfer) begin
                            pend_d  = div_in;
                            state_d = PEND;
                        end
                    end else if (tc) begin
                        load     = 1'b1;
                        load_val = pend_q;
                        state_d  = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        run_d        = (state_d != IDLE);
        tick_d       = run_d && (cnt_nxt == mod_nxt - CNT_W'(1));
        clk_d        = run_d && (cnt_nxt >= (mod_nxt >> 1));
        busy_d       = run_d;
        ready_d      = (state_d != PEND);
        tick_count_d = tcnt_base + {{(CNT_W-1){1'b0}}, tick_d};
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            tick_count_q <= '0;
            tick_q       <= 1'b0;
            clk_q        <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
`ifdef TICK_SCHED_BURST_EN
            burst_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            tick_count_q <= tick_count_d;
            tick_q       <= tick_d;
            clk_q        <= clk_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
`ifdef TICK_SCHED_BURST_EN
            burst_q      <= burst_d;
`endif
        end
    end

    assign oTick       = tick_q;
    assign oClock_out  = clk_q;
    assign oBusy       = busy_q;
    assign oDiv_ready  = ready_q;
    assign oTick_count = tick_count_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed + random bench for tick_scheduler against a period-position reference model.
module tb_tick_scheduler;

    localparam int W = 16;

    logic         iClock = 1'b0;
    logic         iReset, iStart, iStop, iDiv_valid;
    logic [W-1:0] iDiv;
    logic         oDiv_ready, oTick, oClock_out, oBusy;
    logic [W-1:0] oTick_count;
`ifdef TICK_SCHED_BURST_EN
    logic [W-1:0] iBurst;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: running flag, ratio, position within the current period,
    // a single pending-ratio slot, and the tick tally since start.
    bit m_run, m_pv, m_tick;
    int m_div, m_pos, m_pend, m_tc, m_burst;

    always #5 iClock = ~iClock;

    tick_scheduler #(.CNT_W(W), .DEF_DIV(10)) dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iStart      (iStart),
        .iStop       (iStop),
        .iDiv        (iDiv),
        .iDiv_valid  (iDiv_valid),
        .oDiv_ready  (oDiv_ready),
        .oTick       (oTick),
        .oClock_out  (oClock_out),
        .oBusy       (oBusy),
        .oTick_count (oTick_count)
`ifdef TICK_SCHED_BURST_EN
        ,
        .iBurst      (iBurst)
`endif
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pv = 0; m_tick = 0;
        m_div = 10; m_pos = 0; m_pend = 0; m_tc = 0; m_burst = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit v, input int d);
        int  dd;
        bit  xfer;
        dd   = (d == 0) ? 1 : d;
        xfer = v && !(m_run && m_pv);
        if (!m_run) begin
            if (xfer) m_div = dd;
            if (s && !p) begin
                m_run = 1; m_pos = 0; m_tc = 0;
`ifdef TICK_SCHED_BURST_EN
                m_burst = int'(iBurst);
`endif
            end
        end else if (p || (m_burst != 0 && m_tick && m_tc == m_burst)) begin
            m_run = 0; m_pos = 0;
            if (m_pv) m_div = m_pend;
            m_pv = 0;
        end else begin
            if (m_pos == m_div - 1) begin
                m_pos = 0;
                if (m_pv) begin m_div = m_pend; m_pv = 0; end
            end else begin
                m_pos++;
            end
            if (xfer) begin m_pend = dd; m_pv = 1; end
        end
        m_tick = m_run && (m_pos == m_div - 1);
        if (m_tick) m_tc = (m_tc + 1) % 65536;
    endtask

    task automatic check_all();
        chk("tick",   W'(oTick),      W'(m_tick));
        chk("clkout", W'(oClock_out), W'(m_run && (m_pos >= m_div / 2)));
        chk("busy",   W'(oBusy),      W'(m_run));
        chk("ready",  W'(oDiv_ready), W'(!(m_run && m_pv)));
        chk("count",  oTick_count,    W'(m_tc));
    endtask

    task automatic step(input bit s, input bit p, input bit v, input int d);
        iStart = s; iStop = p; iDiv_valid = v; iDiv = W'(d);
        model_step(s, p, v, d);
        @(posedge iClock);
        @(negedge iClock);
        check_all();
    endtask

    initial begin
        iReset = 1'b1; iStart = 0; iStop = 0; iDiv_valid = 0; iDiv = '0;
`ifdef TICK_SCHED_BURST_EN
        iBurst = '0;
`endif
        model_reset();
        @(negedge iClock);
        @(negedge iClock);
        check_all();
        chk("rst_ready", W'(oDiv_ready), W'(1));
        iReset = 1'b0;

        // Default ratio 10 from start.
        step(1, 0, 0, 0);
        chk("busy_start", W'(oBusy), W'(1));
        repeat (29) step(0, 0, 0, 0);
        chk("count30", oTick_count, W'(3));

        // Ratio change mid-period: old period completes, then 4-cycle periods.
        for (int i = 0; i < 20 && m_pos != 3; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 4);
        chk("ready_pend", W'(oDiv_ready), W'(0));
        repeat (5) step(0, 0, 0, 0);
        chk("old_period_tick", W'(oTick), W'(1));
        repeat (4) step(0, 0, 0, 0);
        chk("new_period_tick", W'(oTick), W'(1));
        chk("ready_back", W'(oDiv_ready), W'(1));
        repeat (8) step(0, 0, 0, 0);

        // Ratio 1 and ratio 0 both tick every cycle with the output held high.
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        step(1, 0, 0, 0);
        repeat (4) begin
            step(0, 0, 0, 0);
            chk("div1_tick", W'(oTick), W'(1));
            chk("div1_clk", W'(oClock_out), W'(1));
        end
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        repeat (3) begin
            step(0, 0, 0, 0);
            chk("div0_tick", W'(oTick), W'(1));
        end
        step(0, 1, 0, 0);

        // Stop on the tick edge suppresses the tick; start+stop stays idle.
        step(0, 0, 1, 10);
        step(1, 0, 0, 0);
        for (int i = 0; i < 20 && m_pos != m_div - 2; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("stop_tick", W'(oTick), W'(0));
        chk("stop_busy", W'(oBusy), W'(0));
        step(1, 1, 0, 0);
        chk("startstop_busy", W'(oBusy), W'(0));

        // Asynchronous reset while a ratio of 7 is pending.
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 7);
        chk("pend7_ready", W'(oDiv_ready), W'(0));
        iStart = 0; iStop = 0; iDiv_valid = 0;
        #2 iReset = 1'b1;
        #1;
        chk("arst_busy", W'(oBusy), W'(0));
        chk("arst_tick", W'(oTick), W'(0));
        chk("arst_clk", W'(oClock_out), W'(0));
        chk("arst_count", oTick_count, W'(0));
        chk("arst_ready", W'(oDiv_ready), W'(1));
        model_reset();
        @(negedge iClock);
        iReset = 1'b0;
        check_all();
        step(1, 0, 0, 0);
        repeat (9) step(0, 0, 0, 0);
        chk("rst_def_tick", W'(oTick), W'(1));
        step(0, 1, 0, 0);

`ifdef TICK_SCHED_BURST_EN
        // Budget of 3 ticks at ratio 5.
        step(0, 0, 1, 5);
        iBurst = W'(3);
        step(1, 0, 0, 0);
        repeat (14) step(0, 0, 0, 0);
        chk("burst_tick3", W'(oTick), W'(1));
        step(0, 0, 0, 0);
        chk("burst_busy", W'(oBusy), W'(0));
        chk("burst_count", oTick_count, W'(3));
        repeat (3) step(0, 0, 0, 0);
        iBurst = '0;
`endif

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
`ifdef TICK_SCHED_BURST_EN
            iBurst = W'($urandom_range(0, 4));
`endif
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
